// File: rtl/z_stream_reader_if.sv
// Handshake/bus bundle for the Z-memory stream reader: start/length control,
// memory read port, downstream valid/ready stream and completion status.
interface z_stream_reader_if #(
    parameter int PROD_WIDTH      = 16,
    parameter int MAX_NUM_QUERIES = 256,
    parameter int ADDR_WIDTH      = $clog2(MAX_NUM_QUERIES),
    parameter int SUM_WIDTH       = PROD_WIDTH + ADDR_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH:0]   num_queries;
    logic                  z_rd_req;
    logic                  z_rd_gnt;
    logic [ADDR_WIDTH-1:0] z_addr;
    logic [PROD_WIDTH-1:0] z_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [PROD_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic [SUM_WIDTH-1:0]  sum_out;

    modport master (
        input  start, num_queries, z_rd_gnt, z_rdata, out_ready,
        output z_rd_req, z_addr, out_valid, out_data, out_index, out_last,
               busy, done, sum_out
    );

    modport slave (
        output start, num_queries, z_rd_gnt, z_rdata, out_ready,
        input  z_rd_req, z_addr, out_valid, out_data, out_index, out_last,
               busy, done, sum_out
    );
endinterface

// File: rtl/z_stream_reader.sv
// Sweeps Z memory addresses 0..N-1, streams each value downstream on
// valid/ready, and accumulates the softmax denominator alongside.
module z_stream_reader #(
    parameter int PROD_WIDTH      = 16,
    parameter int MAX_NUM_QUERIES = 256,
    parameter int ADDR_WIDTH      = $clog2(MAX_NUM_QUERIES),
    parameter int SUM_WIDTH       = PROD_WIDTH + ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    z_stream_reader_if.master zs
);
    localparam logic [ADDR_WIDTH:0]   MAX_N     = (ADDR_WIDTH+1)'(MAX_NUM_QUERIES);
    localparam logic [ADDR_WIDTH:0]   N_ZERO    = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   N_ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [SUM_WIDTH-1:0]  SUM_ZERO  = SUM_WIDTH'(0);
    localparam logic [PROD_WIDTH-1:0] DATA_ZERO = PROD_WIDTH'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PROD_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_req_s;
    logic                  accept_s;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= N_ZERO;
            addr_q  <= ADDR_ZERO;
            data_q  <= DATA_ZERO;
            index_q <= ADDR_ZERO;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sum_q   <= SUM_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, capture and handshake logic
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        addr_d   = addr_q;
        data_d   = data_q;
        index_d  = index_q;
        valid_d  = valid_q;
        last_d   = last_q;
        sum_d    = sum_q;
        rd_req_s = 1'b0;
        accept_s = valid_q && zs.out_ready;
        case (state_q)
            IDLE: begin
                if (zs.start) begin
                    n_d     = (zs.num_queries > MAX_N) ? MAX_N : zs.num_queries;
                    addr_d  = ADDR_ZERO;
                    sum_d   = SUM_ZERO;
                    state_d = (n_d == N_ZERO) ? DONE : FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                // Read only when the output slot is free or being drained this cycle
                rd_req_s = !valid_q || zs.out_ready;
                if (rd_req_s && zs.z_rd_gnt) begin
                    data_d  = zs.z_rdata;
                    index_d = addr_q;
                    valid_d = 1'b1;
                    last_d  = ({1'b0, addr_q} == (n_q - N_ONE));
                    sum_d   = sum_q + {{(SUM_WIDTH-PROD_WIDTH){1'b0}}, zs.z_rdata};
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = last_d ? DRAIN : FETCH;
                end else if (accept_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            DRAIN: begin
                if (accept_s && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign zs.z_rd_req  = rd_req_s;
    assign zs.z_addr    = addr_q;
    assign zs.out_valid = valid_q;
    assign zs.out_data  = data_q;
    assign zs.out_index = index_q;
    assign zs.out_last  = last_q;
    assign zs.busy      = busy_q;
    assign zs.done      = done_q;
    assign zs.sum_out   = sum_q;
endmodule
